// File: rtl/obs_trace_pkg.sv
// Shared types and default sizing for the observer trace capture block.
package obs_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } state_t;

  localparam int SYM_W_DEF   = 2;
  localparam int WIN_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int NUM_BINS    = 2 ** SYM_W_DEF;

  // One histogram bin per possible symbol value.
  function automatic int numBins(input int symW);
    return 1 << symW;
  endfunction

endpackage

// File: rtl/obs_hist_bank.sv
// Bank of saturating per-symbol counters; clear has priority over increment.
module obs_hist_bank
  import obs_trace_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inc_en,
  input  logic [SYM_W-1:0]                  inc_idx,
  input  logic                              clear,
  output logic [numBins(SYM_W)*CNT_W-1:0]   hist_out
);

  localparam int BINS = numBins(SYM_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_bins [BINS];

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int b = 0; b < BINS; b++) begin
        r_bins[b] <= '0;
      end
    end else if (inc_en && (r_bins[inc_idx] != CNT_MAX)) begin
      r_bins[inc_idx] <= r_bins[inc_idx] + 1'b1;
    end
  end

  for (genvar b = 0; b < BINS; b++) begin : g_pack
    assign hist_out[b*CNT_W +: CNT_W] = r_bins[b];
  end

endmodule

// File: rtl/obs_trace_capture.sv
// Captures WIN_LEN observed symbols into a packed trace and keeps a symbol histogram.
// Optional macro TRACE_PARITY_EN adds a trace_parity output (XOR of all trace bits).
module obs_trace_capture
  import obs_trace_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [SYM_W-1:0]                  obs_in,
  input  logic                              obs_valid,
  input  logic                              clear_hist,
  output logic [SYM_W*WIN_LEN-1:0]          trace_out,
  output logic                              trace_valid,
  input  logic                              trace_ready,
  output logic [numBins(SYM_W)*CNT_W-1:0]   hist_out,
  output logic                              busy,
  output logic                              overflow
`ifdef TRACE_PARITY_EN
  ,
  output logic                              trace_parity
`endif
);

  localparam int TR_W  = SYM_W * WIN_LEN;
  localparam int IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [TR_W-1:0]   r_trace;
  logic              r_traceValid;
  logic              r_busy;
  logic              r_overflow;

  logic [TR_W-1:0]   w_nextTrace;
  logic              w_sampleEn;
  logic              w_lastSample;

  assign w_sampleEn   = (r_state == CAPTURE) && obs_valid;
  assign w_lastSample = w_sampleEn && (r_idx == LAST_IDX);

  always_comb begin
    w_nextTrace = r_trace;
    w_nextTrace[r_idx*SYM_W +: SYM_W] = obs_in;
  end

  // A start arriving with the handshake is dropped because the FSM is still in HOLD then.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_trace      <= '0;
      r_traceValid <= 1'b0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (clear_hist) begin
        r_overflow <= 1'b0;
      end else if ((r_state == HOLD) && obs_valid) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CAPTURE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (obs_valid) begin
            r_trace <= w_nextTrace;
            if (r_idx == LAST_IDX) begin
              r_state      <= HOLD;
              r_traceValid <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (trace_ready) begin
            r_state      <= IDLE;
            r_traceValid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef TRACE_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_lastSample) begin
      r_parity <= ^w_nextTrace;
    end
  end

  assign trace_parity = r_parity;
`endif

  obs_hist_bank #(
    .SYM_W (SYM_W),
    .CNT_W (CNT_W)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (w_sampleEn),
    .inc_idx  (obs_in),
    .clear    (clear_hist),
    .hist_out (hist_out)
  );

  assign trace_out   = r_trace;
  assign trace_valid = r_traceValid;
  assign busy        = r_busy;
  assign overflow    = r_overflow;

endmodule
